// File: rtl/tdm_scheduler.sv
// Round-robin TDM scheduler: grants one requester per slot of DWELL
// accepted transfers, muxing its data word onto a valid/ready output.
module tdm_scheduler #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int DWELL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [M-1:0]         req,
    input  logic [M*N-1:0]       d,
    input  logic                 ready,
    output logic [N-1:0]         y,
    output logic                 valid,
    output logic [M-1:0]         grant,
    output logic [$clog2(M)-1:0] idx
);

    localparam int IW = $clog2(M);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [IW-1:0] base;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW-1:0] ptr_next;
    logic          xfer;
    logic          slot_end;

    // First requesting index at or after base, wrapping modulo M.
    always_comb begin
        int k;
        k          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < M; i++) begin
            k = (int'(base) + i) % M;
            if (!pick_found && req[k]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(k);
            end
        end
    end

    assign ptr_next = (idx_q == IW'(M - 1)) ? '0 : idx_q + 1'b1;
    assign base     = (state_q == HOLD) ? ptr_next : ptr_q;

    assign valid    = (state_q == HOLD) && req[idx_q];
    assign y        = (state_q == HOLD) ? d[idx_q*N +: N] : '0;
    assign grant    = grant_q;
    assign idx      = idx_q;

    assign xfer     = valid && ready;
    assign slot_end = (state_q == HOLD) &&
                      (!req[idx_q] || (xfer && (cnt_q == '0)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = HOLD;
                    grant_d = M'(1) << pick_idx;
                    idx_d   = pick_idx;
                    cnt_d   = CW'(DWELL - 1);
                end
            end
            HOLD: begin
                if (slot_end) begin
                    ptr_d = ptr_next;
                    if (pick_found) begin
                        grant_d = M'(1) << pick_idx;
                        idx_d   = pick_idx;
                        cnt_d   = CW'(DWELL - 1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/tdm_scheduler.md
TDM_SCHEDULER -- requirements
Module: tdm_scheduler

Interface
REQ-001 SHALL have parameter N, default 8: bit width of each requester data word.
REQ-002 SHALL have parameter M, default 4: number of requesters; legal range M>=2.
REQ-003 SHALL have parameter DWELL, default 2: accepted transfers per grant slot; legal range DWELL>=1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-low; the block resets at a rising clk edge while reset=0.
REQ-006 SHALL have port req, input, M: per-requester request, held high while the requester has data.
REQ-007 SHALL have port d, input, M*N: packed data words, requester k at d[k*N +: N].
REQ-008 SHALL have port ready, input, 1: downstream accepts y this cycle.
REQ-009 SHALL have port y, output, N: data of the granted requester, 0 when nothing is granted.
REQ-010 SHALL have port valid, output, 1: y carries a transfer offer this cycle.
REQ-011 SHALL have port grant, output, M: registered one-hot grant, all-zero when idle.
REQ-012 SHALL have port idx, output, $clog2(M): registered index of the granted requester, 0 when idle.

Function
REQ-013 SHALL implement FSM states IDLE (no grant) and HOLD (one requester granted).
REQ-014 SHALL keep a round-robin pointer ptr in the range 0..M-1; search order ptr, ptr+1, ... modulo M.
REQ-015 IDLE: if any req bit is high, SHALL grant the first requesting index in search order at the next edge, enter HOLD, and load the beat counter with DWELL-1.
REQ-016 IDLE with req=0: SHALL remain in IDLE with grant=0.
REQ-017 SHALL drive valid = (state==HOLD) & req[idx]; y = d[idx*N +: N] in HOLD, else 0; both combinational from registered state.
REQ-018 SHALL count a transfer only on a cycle with valid=1 and ready=1; while ready=0 the counter, grant and idx SHALL hold.
REQ-019 On a transfer with counter==0 the slot SHALL end: ptr <= (idx+1) mod M; counter otherwise decrements by 1.
REQ-020 If req[idx]=0 in HOLD, the slot SHALL end at that edge regardless of counter or ready, with the same ptr update.
REQ-021 At slot end, if any req bit is high, SHALL grant the next requester in search order from the updated ptr at the same edge and stay in HOLD; otherwise SHALL go to IDLE. The ending requester is eligible again; search wraps M-1 -> 0.
REQ-022 Back-to-back slots SHALL have no idle cycle between them.
REQ-023 grant SHALL always be one-hot or all-zero, and grant[idx]=1 whenever in HOLD.
REQ-024 The counter SHALL be sized for values up to DWELL-1; no overflow or underflow path is permitted.

Reset
REQ-025 While reset=0 at a rising clk edge: state<=IDLE, grant<=0, idx<=0, ptr<=0, counter<=0; hence valid=0, y=0 the following cycle.
REQ-026 Reset SHALL dominate all other inputs, including mid-slot and with ready=1.
REQ-027 The first grant after reset release SHALL go to the lowest requesting index.

Verification (M=4, N=8, DWELL=2; d = {8'h44, 8'h33, 8'h22, 8'h11})
REQ-028 Sequence: reset=0 for 2 edges with req=4'b1111, ready=1 -> grant=0, valid=0, y=0; first edge after release -> grant=0001, y=8'h11.
REQ-029 Sequence: req=1111, ready=1 constant -> grant 0001,0001,0010,0010,0100,0100,1000,1000,0001 on successive cycles; y follows 11,11,22,22,33,33,44,44,11.
REQ-030 Sequence: only req=0100 from IDLE -> grant=0100 after 1 edge; it is re-granted after every 2 transfers with valid continuously 1 and no IDLE cycle.
REQ-031 Sequence: req=1111, ready=0 for 5 cycles after grant 0001 -> grant stays 0001, valid=1; ready=1 -> 2 more cycles on 0001, then grant=0010.
REQ-032 Sequence: while granted 0010, req goes 1111 -> 1101 -> next edge grant=0100, ptr=2; with req dropping to 0000 -> next edge grant=0, valid=0.
REQ-033 Sequence: reset=0 for one edge during HOLD on 1000 with ready=1 -> grant=0, idx=0 the next cycle; after release with req=1000 -> grant=1000.
